// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: RAM command opcodes and arbiter FSM state encodings
package ram_ctrl_pkg;
  typedef logic [1:0] cmd_t;
  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; favours the requester not granted last
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_idx
);
  logic ptr_q;
  // priority pointer breaks ties; a lone request always wins
  always_comb gnt_idx = (req == 2'b11) ? ptr_q : req[1];
  // after a grant, priority moves to the other requester
  always_ff @(posedge clk)
    if (rst) ptr_q <= 1'b0;
    else if (advance) ptr_q <= ~gnt_idx;
endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: shares one RAM command port between two read/write requesters
module ram_cmd_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int WORD_SIZE  = 8,
  parameter int INPUT_SIZE = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  req_1,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic [ADDR_SIZE-1:0]  addr_0,
  input  logic [ADDR_SIZE-1:0]  addr_1,
  input  logic [WORD_SIZE-1:0]  wdata_0,
  input  logic [WORD_SIZE-1:0]  wdata_1,
  output logic                  ack_0,
  output logic                  ack_1,
  output logic                  err_0,
  output logic                  err_1,
  output logic [WORD_SIZE-1:0]  rdata,
  output logic [INPUT_SIZE-1:0] ram_din,
  output logic                  ram_rx_valid,
  input  logic [WORD_SIZE-1:0]  ram_dout,
  input  logic                  ram_tx_valid
);
  localparam int PW = INPUT_SIZE - 2;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [2:0]           state_q, state_d;
  logic                 gnt_q, we_q, err_q, gnt_idx, advance, timeout;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q, rdata_q;
  logic [CW-1:0]        cnt_q;
  assign advance = (state_q == S_IDLE) && (req_0 || req_1);
  assign timeout = cnt_q == CW'(TIMEOUT - 1);
  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req_1, req_0}),
    .advance (advance),
    .gnt_idx (gnt_idx)
  );
  // next-state: address word, data/trigger word, optional read wait, ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = advance ? S_ADDR : S_IDLE;
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT:  state_d = (ram_tx_valid || timeout) ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  // state, latched request fields, timeout counter and read result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        gnt_q   <= gnt_idx;
        we_q    <= gnt_idx ? we_1 : we_0;
        addr_q  <= gnt_idx ? addr_1 : addr_0;
        wdata_q <= gnt_idx ? wdata_1 : wdata_0;
      end
      if (state_q == S_DATA) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + CW'(1);
        if (ram_tx_valid) rdata_q <= ram_dout;
        else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end
  assign ram_rx_valid = (state_q == S_ADDR) || (state_q == S_DATA);
  assign ram_din = (state_q == S_ADDR) ? {(we_q ? CMD_WR_ADDR : CMD_RD_ADDR), PW'(addr_q)} :
                   (state_q == S_DATA) ? (we_q ? {CMD_WR_DATA, PW'(wdata_q)} : {CMD_RD_DATA, {PW{1'b0}}}) :
                   '0;
  assign ack_0 = (state_q == S_DONE) && !gnt_q;
  assign ack_1 = (state_q == S_DONE) && gnt_q;
  assign err_0 = ack_0 && err_q;
  assign err_1 = ack_1 && err_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter: directed vector table plus hand-written arbitration and reset sequences
module tb_ram_cmd_arbiter;
  logic       clk = 0, rst = 1;
  logic       req_0 = 0, req_1 = 0, we_0 = 0, we_1 = 0;
  logic [7:0] addr_0 = 0, addr_1 = 0, wdata_0 = 0, wdata_1 = 0;
  logic       ack_0, ack_1, err_0, err_1;
  logic [7:0] rdata, ram_dout = 0;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid = 0;
  int total = 0, bad = 0;

  ram_cmd_arbiter dut (
    .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .ack_0(ack_0), .ack_1(ack_1), .err_0(err_0), .err_1(err_1), .rdata(rdata),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
    .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         k;
    bit         spur;
    logic [9:0] exp_a;
    logic [9:0] exp_d;
    int         exp_cyc;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [9:0] d[$];
    int cyc = 0;
    logic [7:0] rd = 0;
    logic er = 0;
    bit other = 0, din_leak = 0;
    if (v.r) begin req_1 = 1; we_1 = v.we; addr_1 = v.addr; wdata_1 = v.wdata; end
    else begin req_0 = 1; we_0 = v.we; addr_0 = v.addr; wdata_0 = v.wdata; end
    @(posedge clk);
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      @(negedge clk);
      if (ram_rx_valid) d.push_back(ram_din);
      else if (ram_din != 0) din_leak = 1;
      if (v.r ? ack_0 : ack_1) other = 1;
      if (v.r ? ack_1 : ack_0) begin
        cyc = c; rd = rdata; er = v.r ? err_1 : err_0;
        req_0 = 0; req_1 = 0;
      end
      ram_tx_valid = (v.spur && c == 1) || (v.k >= 0 && c == 3 + v.k);
      ram_dout = (v.spur && c == 1) ? 8'hEE : v.wdata;
    end
    ram_tx_valid = 0;
    req_0 = 0; req_1 = 0;
    chk($sformatf("v%0d_ncmd", n), d.size(), 2);
    chk($sformatf("v%0d_din0", n), (d.size() > 0) ? d[0] : 10'h3ff, v.exp_a);
    chk($sformatf("v%0d_din1", n), (d.size() > 1) ? d[1] : 10'h3ff, v.exp_d);
    chk($sformatf("v%0d_ackcyc", n), cyc, v.exp_cyc);
    chk($sformatf("v%0d_err", n), er, v.exp_err);
    chk($sformatf("v%0d_otherack", n), other, 0);
    chk($sformatf("v%0d_dinidle", n), din_leak, 0);
    if (!v.we) chk($sformatf("v%0d_rdata", n), rd, v.exp_rd);
    @(negedge clk);
  endtask

  vec_t vecs[9];
  int order[3], acyc[3], na;
  logic [9:0] first_addr[3];

  initial begin
    vecs[0] = '{0, 1, 8'h01, 8'h0A, -1, 0, 10'h001, 10'h10A, 3,  8'h00, 0};
    vecs[1] = '{0, 0, 8'h01, 8'h0A,  0, 0, 10'h201, 10'h300, 4,  8'h0A, 0};
    vecs[2] = '{1, 1, 8'hFF, 8'h55, -1, 0, 10'h0FF, 10'h155, 3,  8'h00, 0};
    vecs[3] = '{1, 0, 8'h80, 8'hC3,  2, 0, 10'h280, 10'h300, 6,  8'hC3, 0};
    vecs[4] = '{0, 0, 8'h33, 8'h99, -1, 0, 10'h233, 10'h300, 19, 8'h00, 1};
    vecs[5] = '{1, 0, 8'h12, 8'h5C,  1, 1, 10'h212, 10'h300, 5,  8'h5C, 0};
    vecs[6] = '{0, 0, 8'h00, 8'h7E,  5, 0, 10'h200, 10'h300, 9,  8'h7E, 0};
    vecs[7] = '{1, 0, 8'hFE, 8'h11, -1, 0, 10'h2FE, 10'h300, 19, 8'h00, 1};
    vecs[8] = '{0, 0, 8'h44, 8'hA5, 15, 0, 10'h244, 10'h300, 19, 8'hA5, 0};

    repeat (2) @(negedge clk);
    chk("rst_ctl", {ack_0, ack_1, err_0, err_1, ram_rx_valid}, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;

    req_0 = 1; req_1 = 1; we_0 = 1; we_1 = 1;
    addr_0 = 8'h10; addr_1 = 8'h20; wdata_0 = 8'h11; wdata_1 = 8'h22;
    na = 0;
    @(posedge clk);
    for (int c = 1; c <= 30 && na < 3; c++) begin
      @(negedge clk);
      if (ram_rx_valid && ram_din[9:8] == 2'b00) first_addr[na] = ram_din;
      if (ack_0 || ack_1) begin
        order[na] = ack_1 ? 1 : 0; acyc[na] = c; na++;
      end
    end
    req_0 = 0; req_1 = 0;
    chk("arb_count", na, 3);
    chk("arb_order0", order[0], 0);
    chk("arb_order1", order[1], 1);
    chk("arb_order2", order[2], 0);
    chk("arb_cyc0", acyc[0], 3);
    chk("arb_cyc1", acyc[1], 7);
    chk("arb_cyc2", acyc[2], 11);
    chk("arb_addr1", first_addr[1], 10'h020);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    req_0 = 1; we_0 = 0; addr_0 = 8'h66;
    @(posedge clk);
    repeat (4) @(negedge clk);
    chk("wait_nostrobe", ram_rx_valid, 0);
    rst = 1; req_0 = 0;
    @(negedge clk);
    chk("midrst_ctl", {ack_0, ack_1, err_0, err_1, ram_rx_valid}, 0);
    chk("midrst_din", ram_din, 0);
    chk("midrst_rdata", rdata, 0);
    rst = 0;
    req_0 = 1; req_1 = 1; we_0 = 1; we_1 = 1; addr_0 = 8'h70; addr_1 = 8'h71;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_grant", ram_din, 10'h070);
    repeat (2) @(negedge clk);
    chk("postrst_ack", {ack_0, ack_1}, 2'b10);
    req_0 = 0; req_1 = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ram_cmd_arbiter.md
# ram_cmd_arbiter

Shares one single-port RAM command port (10-bit command word, `rx_valid`/`tx_valid` handshake) between two requesters. Each requester issues a complete read or write transaction. The block expands it into the RAM's two-step command sequence: address word, then data or read-trigger word. For reads it waits for `tx_valid` and returns the data. It sits between the SPI slave and local host logic on one side and the RAM on the other.

## Interface
Parameters:
- `ADDR_SIZE`, 8, RAM address width.
- `WORD_SIZE`, 8, RAM data width.
- `INPUT_SIZE`, 10, RAM command width. Must equal `max(ADDR_SIZE, WORD_SIZE) + 2`.
- `TIMEOUT`, 16, maximum cycles to wait for `tx_valid` on a read. Must be at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_0`, `req_1`  in  1 each  transaction request from requester 0 / 1.
- `we_0`, `we_1`  in  1 each  1 = write, 0 = read.
- `addr_0`, `addr_1`  in  `ADDR_SIZE` each  target address.
- `wdata_0`, `wdata_1`  in  `WORD_SIZE` each  write data.
- `ack_0`, `ack_1`  out  1 each  one-cycle completion pulse.
- `err_0`, `err_1`  out  1 each  valid with ack; read timed out.
- `rdata`  out  `WORD_SIZE`  read data, shared by both requesters, valid with ack.
- `ram_din`  out  `INPUT_SIZE`  command word to RAM; bits [9:8] are the opcode.
- `ram_rx_valid`  out  1  command strobe to RAM.
- `ram_dout`  in  `WORD_SIZE`  RAM read data.
- `ram_tx_valid`  in  1  RAM read data valid.

## Operation
Opcodes:
- 00: write address.
- 01: write data.
- 10: read address.
- 11: read trigger. Payload is 0.

Requester rules:
- Hold `req`, `we`, `addr` and `wdata` stable until `ack`.
- Drop `req` in the cycle after `ack`. If `req` is still high in the next IDLE, it is treated as a new transaction.

Arbitration:
- Round-robin, evaluated only in IDLE.
- If only one `req` is high, that requester is granted.
- If both are high, the requester not granted last wins.
- After reset, requester 0 has priority.
- The grant index and request fields are latched on entry to ADDR.

State machine:
- IDLE: wait for any `req`; go to ADDR.
- ADDR: `ram_rx_valid = 1`. `ram_din` = {00 or 10, addr}. Go to DATA.
- DATA: `ram_rx_valid = 1`. `ram_din` = {01, wdata} for a write, {11, 0} for a read.
  - Write: go to DONE.
  - Read: go to WAIT_RD and clear the timeout counter.
- WAIT_RD:
  - `ram_tx_valid` high: latch `ram_dout` into `rdata`, go to DONE with err = 0.
  - Otherwise, when the counter reaches `TIMEOUT - 1`: set `rdata = 0`, go to DONE with err = 1.
  - Otherwise the counter increments.
- DONE: the granted requester's `ack` is high and its `err` is valid for this one cycle. Go to IDLE.

Other rules:
- `ram_tx_valid` outside WAIT_RD is ignored.
- Every transaction re-sends its address, so a stale RAM address latch is harmless.
- Reset at any point: state IDLE, round-robin pointer to 0, counter 0, and outputs to their reset values. Any in-flight transaction is dropped with no ack.

## Timing
Reset values:
- `ack_*`, `err_*`, `ram_rx_valid`: 0.
- `rdata`, `ram_din`: 0.

Output timing:
- All outputs are registered or Moore-decoded from state. There is no combinational path from inputs to outputs.
- `ram_din` reads 0 whenever `ram_rx_valid` is 0.

Latency, with `req` first sampled high in IDLE at edge 0:
- Write: ADDR in cycle 1, DATA in cycle 2, `ack` in cycle 3.
- Read with `tx_valid` k cycles into WAIT_RD (k ≥ 0): `ack` in cycle 4 + k.
- Read timeout: `ack` with err in cycle 3 + `TIMEOUT`.

Throughput: there is one IDLE cycle between transactions. Back-to-back writes therefore take 4 cycles each.

## Structure
Package `ram_ctrl_pkg` holds:
- Opcode constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
- State encodings for IDLE, ADDR, DATA, WAIT_RD, DONE.

One sub-module, `rr_arbiter_2`, contains:
- inputs `req[1:0]` and `advance`;
- output `gnt_idx`;
- the registered last-grant pointer.

## Test plan
- Requester 0 writes 0x0A to 0x01, then reads 0x01. Expect `ram_din` sequence 0x001, 0x10A, 0x201, 0x300. Expect `ack_0` with `rdata = 0x0A` and `err_0 = 0`.
- `req_0` and `req_1` both high after reset. Expect requester 0 served first, then requester 1, then requester 0 again if both stay asserted.
- Read with `ram_tx_valid` held low and `TIMEOUT = 16`. Expect `ack` with err = 1 and `rdata = 0` in cycle 19.
- Read where a spurious `ram_tx_valid` arrives during ADDR. Expect it ignored; the later valid 0x5C is returned.
- `rst` asserted during WAIT_RD. Expect the next cycle to show IDLE, all outputs 0, no ack, and the next request granted to requester 0.
